uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial transmitter directly downstream of the dump unit. Consumes the byte stream the dump unit presents on its valid/ready handshake (sample high byte, sample low byte, 0xFF sync) and emits it as 8N1 asynchronous serial on a single TX line.
- Supplies the ready signal the dump unit waits on before it advances to the next byte.
- The baud rate comes from a fixed clock divider.

Parameters:
- UART_DATA_SIZE, 8: data bits per frame.
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200); legal range >= 2.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- i_clock  input  1  system clock; all logic on posedge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  byte on i_data offered for transmission.
- i_data  input  UART_DATA_SIZE  byte to send; sampled only on the accept cycle.
- o_ready  output  1  high when idle and able to accept a byte.
- o_tx  output  1  serial line; idles high.
- o_busy  output  1  high while a frame is on the line (inverse of o_ready).
- o_done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (i_reset high at posedge): next cycle o_tx=1, o_ready=1, o_busy=0, o_done=0. Bit counter, baud counter and shift register are cleared. Reset overrides all other inputs.
- Accept: at a posedge where state==IDLE and i_valid=1, i_data is latched into the shift register.
  - Accept at edge T. From T+1: o_ready=0, o_busy=1, o_tx=0 (start bit).
  - While busy, i_valid and i_data are ignored. The dump unit holds valid for several cycles; this produces exactly one frame.
- States: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  - IDLE: o_tx=1. Go to START on accept.
  - START: o_tx=0 for CLKS_PER_BIT cycles.
  - DATA: UART_DATA_SIZE bits, LSB first, each held CLKS_PER_BIT cycles. The shift register shifts right at each bit boundary.
  - STOP: o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Baud counter:
  - Runs 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Wraps to 0 at each bit boundary. Reset to 0 on accept.
- Frame length: F = (1 + UART_DATA_SIZE + STOP_BITS) * CLKS_PER_BIT cycles, running T+1 .. T+F.
- End of frame:
  - At T+F+1: state=IDLE, o_ready=1, o_busy=0, o_done=1 for exactly one cycle.
  - If i_valid is high at edge T+F+1, that byte is accepted there: o_done=1 and o_ready=1 during cycle T+F+1, start bit begins at T+F+2. This is the back-to-back case; no gap cycle beyond the one idle cycle.
- o_tx is registered; there is no combinational path from any input to o_tx or o_ready.
- Reset mid-frame: the frame is aborted and o_tx returns high the next cycle. A truncated frame on the line is accepted behaviour.
- Simultaneous i_reset and i_valid: reset wins and the byte is dropped.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of all data bits) for CLKS_PER_BIT cycles, and F grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; the frame is 8N1 as above.

Test Plan:
- Reset: hold i_reset 3 cycles with i_valid=1, i_data=0x55 -> o_tx=1, o_ready=1, o_busy=0, o_done=0 throughout; no frame starts.
- Single byte, CLKS_PER_BIT=4, i_valid pulsed with 0xA5 -> o_tx bits 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each exactly 4 cycles. o_ready low 40 cycles, then o_done pulses once.
- Dump-unit handshake: i_valid held 4 cycles per byte for sequence 0x12, 0x34, 0xFF, with each next byte issued after o_ready rises -> exactly three frames decoded as 0x12, 0x34, 0xFF; no duplicates.
- Back-to-back: i_valid held continuously with 0x00 then 0xFF -> second start bit begins the cycle after o_done's accept edge. Decoded 0x00, 0xFF.
- Reset mid-frame: assert i_reset during data bit 3 of 0x0F -> o_tx=1 the next cycle, o_ready=1. A new byte 0x81 is then sent correctly.
- UART_TX_PARITY_EN defined, CLKS_PER_BIT=4: send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1. Frame 44 cycles each.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 serial transmitter fed by a valid/ready byte stream; baud from a fixed clock divider.
// Optional even-parity bit between data and stop bits is enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
  parameter int UART_DATA_SIZE = 8,
  parameter int CLKS_PER_BIT   = 868,
  parameter int STOP_BITS      = 1
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic [UART_DATA_SIZE-1:0] i_data,
  output logic                      o_ready,
  output logic                      o_tx,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [2:0]                o_state
);

  // Handshake: a byte transfers at a posedge where i_valid and o_ready are both high.
  // o_ready is a pure function of registered state, so the upstream may hold i_valid
  // for several cycles; only the first accepted cycle starts a frame.

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (UART_DATA_SIZE > 1) ? $clog2(UART_DATA_SIZE) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(UART_DATA_SIZE - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [UART_DATA_SIZE-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      done_q, done_d;
  logic                      baud_tick;
`ifdef UART_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // tx_d is the line level for the next cycle, so o_tx is a plain flop output.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    baud_tick = (baud_q == BAUD_LAST);

    if (state_q != S_IDLE) begin
      baud_d = baud_tick ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (i_valid) begin
          state_d = S_START;
          shift_d = i_data;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^i_data;
`endif
        end
      end
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        // bit_q counts stop bits here; done fires as the last one ends.
        if (baud_tick) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_busy  = ~o_ready;
  assign o_tx    = tx_q;
  assign o_done  = done_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLKS_PER_BIT=4: byte stimulus feeds an expected queue, a line
// decoder pops and compares each received frame. Honours UART_TX_PARITY_EN.
module tb_uart_tx;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int NBITS = 1 + 8 + PAR_BITS + 1;
  localparam int F     = NBITS * C;

  logic       clk = 1'b0;
  logic       i_reset, i_valid;
  logic [7:0] i_data;
  logic       o_ready, o_tx, o_busy, o_done;
  logic [2:0] o_state;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  int n_sent = 0;

  uart_tx #(.UART_DATA_SIZE(8), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done), .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- line decoder / scoreboard ----------------
  int         cyc = 0;
  bit         in_frame = 0;
  bit         done_pend = 0;
  int         pos, glitch, frames_seen = 0, busy_err = 0, done_spur = 0;
  int         start_cyc;
  logic       cur, mon_par;
  logic [7:0] mon_byte, exp_b;
  int         mon_start_q[$];
  int         mon_end_q[$];

  always @(negedge clk) begin
    int bitn, ph;
    cyc++;
    if (o_busy === o_ready) busy_err++;
    if (i_reset === 1'b1) begin
      in_frame  = 0;
      done_pend = 0;
    end else begin
      if (!in_frame) begin
        if (done_pend) begin
          check_eq("done_pulse", o_done, 1);
          check_eq("ready_after_frame", o_ready, 1);
          done_pend = 0;
        end else if (o_done === 1'b1) begin
          done_spur++;
        end
        if (o_tx === 1'b0) begin
          in_frame  = 1;
          pos       = 0;
          glitch    = 0;
          start_cyc = cyc;
        end
      end
      if (in_frame) begin
        bitn = pos / C;
        ph   = pos % C;
        if (o_ready !== 1'b0 || o_done !== 1'b0) glitch++;
        if (ph == 0) begin
          cur = o_tx;
          if (bitn >= 1 && bitn <= 8) mon_byte[bitn-1] = o_tx;
          else if (bitn == 9 && PAR_BITS == 1) mon_par = o_tx;
          else if (bitn >= 9 + PAR_BITS && o_tx !== 1'b1) glitch++;
        end else if (o_tx !== cur) begin
          glitch++;
        end
        pos++;
        if (pos == F) begin
          in_frame = 0;
          done_pend = 1;
          frames_seen++;
          mon_start_q.push_back(start_cyc);
          mon_end_q.push_back(cyc);
          check_eq("frame_shape", glitch, 0);
          if (exp_q.size() == 0) begin
            check_eq("extra_frame", frames_seen, n_sent);
          end else begin
            exp_b = exp_q.pop_front();
            check_eq("rx_byte", mon_byte, exp_b);
`ifdef UART_TX_PARITY_EN
            check_eq("parity_bit", mon_par, ^exp_b);
`endif
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_level(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (o_ready !== lvl && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (o_ready !== lvl) check_eq(tag, o_ready, lvl);
  endtask

  task automatic send_byte(input logic [7:0] d, input int hold);
    wait_level(1'b1, 200, "ready_timeout");
    i_valid = 1'b1;
    i_data  = d;
    exp_q.push_back(d);
    n_sent++;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, idx;
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'h55;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("rst_tx", o_tx, 1);
      check_eq("rst_ready", o_ready, 1);
      check_eq("rst_busy", o_busy, 0);
      check_eq("rst_done", o_done, 0);
    end
    i_reset = 1'b0;
    i_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check_eq("idle_tx", o_tx, 1);
    check_eq("idle_ready", o_ready, 1);

    // single byte, one-cycle valid; ready low for exactly one frame
    send_byte(8'hA5, 1);
    cnt = 0;
    @(negedge clk);
    while (o_ready === 1'b0 && cnt < 500) begin
      cnt++;
      @(negedge clk);
    end
    check_eq("ready_low_cycles", cnt, F);
    check_eq("done_at_end", o_done, 1);
    @(negedge clk);
    check_eq("done_one_cycle", o_done, 0);
    drain();

    // dump-unit handshake: valid held 4 cycles per byte
    send_byte(8'h12, 4);
    send_byte(8'h34, 4);
    send_byte(8'hFF, 4);
    drain();

    // back-to-back with valid held continuously
    idx = mon_end_q.size();
    wait_level(1'b1, 200, "b2b_ready0");
    i_valid = 1'b1;
    i_data  = 8'h00;
    exp_q.push_back(8'h00);
    n_sent++;
    wait_level(1'b0, 10, "b2b_accept0");
    i_data = 8'hFF;
    exp_q.push_back(8'hFF);
    n_sent++;
    wait_level(1'b1, 200, "b2b_ready1");
    wait_level(1'b0, 10, "b2b_accept1");
    i_valid = 1'b0;
    drain();
    if (mon_start_q.size() >= idx + 2)
      check_eq("b2b_gap", mon_start_q[idx+1] - mon_end_q[idx], 2);
    else
      check_eq("b2b_frames", mon_start_q.size(), idx + 2);

    // reset during data bit 3 of 0x0F, then a clean byte
    send_byte(8'h0F, 1);
    repeat (17) begin
      @(posedge clk); #1;
    end
    i_reset = 1'b1;
    void'(exp_q.pop_back());
    n_sent--;
    @(posedge clk); #1;
    check_eq("abort_tx", o_tx, 1);
    check_eq("abort_ready", o_ready, 1);
    check_eq("abort_busy", o_busy, 0);
    check_eq("abort_done", o_done, 0);
    i_reset = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    send_byte(8'h81, 1);
    drain();

`ifdef UART_TX_PARITY_EN
    send_byte(8'h07, 1);
    drain();
    check_eq("parity_07", mon_par, 1);
`endif

    // random bytes with random valid hold
    for (int k = 0; k < 4; k++) begin
      send_byte(8'($urandom_range(0, 255)), $urandom_range(1, 6));
    end
    drain();

    check_eq("frames_total", frames_seen, n_sent);
    check_eq("busy_not_inverse", busy_err, 0);
    check_eq("stray_done", done_spur, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
